// File: rtl/sudoku_checker.sv
// Read-back verifier for the solver output RAM: streams all 81 cells, checks
// clues against the ROM and all 27 units, and latches the first error found.
module sudoku_checker #(
  parameter int CLUE_CHECK = 1,
  parameter int MEM_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ROM_rd,
  output logic [6:0] ROM_A,
  input  logic [7:0] ROM_Q,
  output logic       RAM_ceb,
  output logic       RAM_web,
  output logic [6:0] RAM_A,
  input  logic [7:0] RAM_Q,
  output logic       done,
  output logic       pass,
  output logic [1:0] err_code,
  output logic [6:0] err_cell,
  output logic [4:0] err_unit
);

  typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [6:0]         addr_q, addr_d;
  logic               issue_q, issue_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [6:0]         idx_q [MEM_LAT];
  logic [6:0]         idx_d [MEM_LAT];
  logic [4:0]         unit_q, unit_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [6:0]         err_cell_q, err_cell_d;
  logic [4:0]         err_unit_q, err_unit_d;
  logic [8:0]         grid_q [81];
  logic [8:0]         grid_d [81];

  logic       issuing;
  logic       cap_vld;
  logic [6:0] cap_idx;
  logic       cap_range_err;
  logic       cap_clue_err;
  logic [8:0] cap_hot;
  logic [8:0] unit_mask;
  int unsigned u, b, ci;

  assign issuing       = (state_q == READ) && issue_q;
  assign cap_vld       = (state_q == READ) && vld_q[MEM_LAT-1];
  assign cap_idx       = idx_q[MEM_LAT-1];
  assign cap_range_err = (RAM_Q == 8'd0) || (RAM_Q > 8'd9);
  assign cap_clue_err  = (CLUE_CHECK != 0) && (ROM_Q != 8'd0) && (ROM_Q != RAM_Q);
  assign cap_hot       = cap_range_err ? '0 : (9'b1 << (RAM_Q - 8'd1));

  // Grid holds one-hot value masks so a unit check is a 9-way OR.
  always_comb begin
    unit_mask = '0;
    u  = 32'(unit_q);
    b  = 0;
    ci = 0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (u < 9) begin
        ci = u * 9 + i;
      end else if (u < 18) begin
        ci = i * 9 + (u - 9);
      end else begin
        b  = u - 18;
        ci = (b / 3) * 27 + (b % 3) * 3 + (i / 3) * 9 + (i % 3);
      end
      unit_mask = unit_mask | grid_q[7'(ci)];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = issue_q;
    unit_d     = unit_q;
    err_code_d = err_code_q;
    err_cell_d = err_cell_q;
    err_unit_d = err_unit_q;
    grid_d     = grid_q;
    vld_d      = '0;
    for (int unsigned i = 0; i < MEM_LAT; i++) idx_d[i] = '0;

    // Read pipeline: address issued now is captured MEM_LAT cycles later.
    for (int unsigned i = MEM_LAT - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    vld_d[0] = issuing;
    idx_d[0] = addr_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = READ;
          addr_d     = '0;
          issue_d    = 1'b1;
          err_code_d = '0;
          err_cell_d = '0;
          err_unit_d = '0;
        end
      end
      READ: begin
        if (issue_q) begin
          addr_d  = (addr_q == 7'd80) ? 7'd0 : addr_q + 7'd1;
          issue_d = (addr_q != 7'd80);
        end
        if (cap_vld) begin
          grid_d[cap_idx] = cap_hot;
          if (err_code_q == 2'd0) begin
            if (cap_range_err) begin
              err_code_d = 2'd1;
              err_cell_d = cap_idx;
            end else if (cap_clue_err) begin
              err_code_d = 2'd2;
              err_cell_d = cap_idx;
            end
          end
          if (cap_idx == 7'd80) begin
            state_d = CHECK;
            unit_d  = '0;
          end
        end
      end
      CHECK: begin
        if ((err_code_q == 2'd0) && (unit_mask != 9'h1FF)) begin
          err_code_d = 2'd3;
          err_unit_d = unit_q;
        end
        unit_d = unit_q + 5'd1;
        if (unit_q == 5'd26) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issue_q    <= 1'b0;
      vld_q      <= '0;
      unit_q     <= '0;
      err_code_q <= '0;
      err_cell_q <= '0;
      err_unit_q <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) idx_q[i] <= '0;
      for (int unsigned i = 0; i < 81; i++) grid_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
      unit_q     <= unit_d;
      err_code_q <= err_code_d;
      err_cell_q <= err_cell_d;
      err_unit_q <= err_unit_d;
      grid_q     <= grid_d;
    end
  end

  assign ROM_rd   = issuing && (CLUE_CHECK != 0);
  assign ROM_A    = issuing ? addr_q : '0;
  assign RAM_ceb  = issuing;
  assign RAM_web  = 1'b1;
  assign RAM_A    = issuing ? addr_q : '0;
  assign done     = (state_q == DONE);
  assign pass     = done && (err_code_q == 2'd0);
  assign err_code = err_code_q;
  assign err_cell = err_cell_q;
  assign err_unit = err_unit_q;

endmodule
